// File: rtl/audio_pkg.sv
// Shared audio types: note codes, sequencer states and
// the sheet-music index limit.
package audio_pkg;

  localparam int MAX_NOTE_INDEX = 31;

  typedef enum logic [3:0] {
    NOTE_DO      = 4'h0,
    NOTE_RE      = 4'h1,
    NOTE_MI      = 4'h2,
    NOTE_FA      = 4'h3,
    NOTE_SOL     = 4'h4,
    NOTE_LA      = 4'h5,
    NOTE_SI      = 4'h6,
    NOTE_DO_HI   = 4'h7,
    NOTE_SILENCE = 4'hF
  } music_note_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    GAP,
    DONE
  } seq_state_e;

endpackage

// File: rtl/beat_timer.sv
// Free-running beat divider: pulses beatTick on the last
// cycle of every beat while run is high.
module beat_timer #(
  parameter int CLKS_PER_BEAT = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic beatTick
);

  localparam int W = $clog2(CLKS_PER_BEAT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BEAT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign beatTick = run && (cnt == LAST);

endmodule

// File: rtl/melody_sequencer.sv
// Walks a sheet-music ROM note by note, timing each note
// in beats and inserting an articulation gap between notes.
module melody_sequencer
  import audio_pkg::*;
#(
  parameter int CLKS_PER_BEAT = 12_500_000,
  parameter int GAP_CLKS      = 1_250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loopEn,
  input  logic [3:0] melodySelect,
  output logic [3:0] melodySelectOut,
  output logic [4:0] noteIndex,
  input  logic [3:0] tone,
  input  logic [3:0] note_length,
  output logic [3:0] toneOut,
  output logic       enableSound,
  output logic       busy,
  output logic       melodyDone
);

  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [4:0] LAST_IDX = 5'(MAX_NOTE_INDEX);

  seq_state_e       state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [4:0]       idx_q, idx_d;
  logic [3:0]       tone_q, tone_d;
  logic [3:0]       beat_q, beat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             en_q, en_d;
  logic             advance;
  logic             beat_tick;

  beat_timer #(
    .CLKS_PER_BEAT(CLKS_PER_BEAT)
  ) u_beat_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != PLAY),
    .run     (state_q == PLAY),
    .beatTick(beat_tick)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    tone_d  = tone_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          sel_d   = melodySelect;
          idx_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (note_length == 4'd0) begin
          state_d = DONE;
        end else begin
          tone_d  = tone;
          beat_d  = note_length;
          state_d = PLAY;
        end
      end
      PLAY: begin
        gap_d = '0;
        if (beat_tick) begin
          beat_d = beat_q - 1'b1;
          if (beat_q == 4'd1) begin
            if (GAP_CLKS == 0) advance = 1'b1;
            else state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) advance = 1'b1;
        else gap_d = gap_q + 1'b1;
      end
      DONE: begin
        idx_d   = '0;
        state_d = loopEn ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // the last ROM slot ends the melody rather than wrapping
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = FETCH;
      end
    end
    if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
    end
    en_d = (state_d == PLAY) && (tone_d != NOTE_SILENCE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      tone_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      tone_q  <= tone_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      en_q    <= en_d;
    end
  end

  assign melodySelectOut = sel_q;
  assign noteIndex       = idx_q;
  assign toneOut         = tone_q;
  assign enableSound     = en_q;
  assign busy            = (state_q != IDLE);
  assign melodyDone      = (state_q == DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: a note-level melody model expands each
// start into a per-cycle expectation queue for the monitor.
module tb_melody_sequencer;

  localparam int CPB = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loopEn = 1'b0;
  logic [3:0] melodySelect = 4'd0;
  logic [3:0] melodySelectOut;
  logic [4:0] noteIndex;
  logic [3:0] tone;
  logic [3:0] note_length;
  logic [3:0] toneOut;
  logic       enableSound;
  logic       busy;
  logic       melodyDone;

  logic [3:0] rom_tone [16][32];
  logic [3:0] rom_len  [16][32];

  assign tone        = rom_tone[melodySelectOut][noteIndex];
  assign note_length = rom_len[melodySelectOut][noteIndex];

  melody_sequencer #(
    .CLKS_PER_BEAT(CPB),
    .GAP_CLKS     (GAP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .loopEn         (loopEn),
    .melodySelect   (melodySelect),
    .melodySelectOut(melodySelectOut),
    .noteIndex      (noteIndex),
    .tone           (tone),
    .note_length    (note_length),
    .toneOut        (toneOut),
    .enableSound    (enableSound),
    .busy           (busy),
    .melodyDone     (melodyDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       en;
    logic       done;
    logic       chk_idx;
    logic       chk_tone;
    logic       chk_sel;
    logic [4:0] idx;
    logic [3:0] tone;
    logic [3:0] sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t mk(bit b, bit e, bit d,
                              bit ci, int i,
                              bit ct, int t,
                              bit cs, int s);
    exp_t x;
    x.busy = b; x.en = e; x.done = d;
    x.chk_idx = ci; x.idx = 5'(i);
    x.chk_tone = ct; x.tone = 4'(t);
    x.chk_sel = cs; x.sel = 4'(s);
    return x;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (busy !== mon_e.busy || enableSound !== mon_e.en ||
          melodyDone !== mon_e.done ||
          (mon_e.chk_idx && noteIndex !== mon_e.idx) ||
          (mon_e.chk_tone && toneOut !== mon_e.tone) ||
          (mon_e.chk_sel && melodySelectOut !== mon_e.sel)) begin
        failures++;
        $display("FAIL cycle_check t=%0t got busy=%b en=%b done=%b idx=%0d tone=%h sel=%h want busy=%b en=%b done=%b idx=%0d(%b) tone=%h(%b) sel=%h(%b)",
          $time, busy, enableSound, melodyDone, noteIndex,
          toneOut, melodySelectOut, mon_e.busy, mon_e.en,
          mon_e.done, mon_e.idx, mon_e.chk_idx, mon_e.tone,
          mon_e.chk_tone, mon_e.sel, mon_e.chk_sel);
      end
    end
  end

  // Note-level model: fetch, len beats of play, gap, advance.
  task automatic model_run(input int sel, input bit lp,
                           input int limit, input bit kill);
    exp_t tr[$];
    int idx = 0;
    bit ended = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (!(limit > 0 && tr.size() >= limit)) begin
      int len = int'(rom_len[sel][idx]);
      int t   = int'(rom_tone[sel][idx]);
      bit fin = 0;
      tr.push_back(mk(1, 0, 0, 1, idx, 0, 0, 1, sel));
      if (len != 0) begin
        for (int c = 0; c < len * CPB; c++)
          tr.push_back(mk(1, t != 15, 0, 1, idx, 1, t, 1, sel));
        for (int c = 0; c < GAP; c++)
          tr.push_back(mk(1, 0, 0, 1, idx, 1, t, 1, sel));
        if (idx == 31) fin = 1;
        else idx++;
      end else begin
        fin = 1;
      end
      if (fin) begin
        tr.push_back(mk(1, 0, 1, 1, idx, 0, 0, 1, sel));
        if (lp) idx = 0;
        else begin ended = 1; break; end
      end
    end
    if (ended) begin
      tr.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      while (limit > 0 && tr.size() < limit)
        tr.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    if (limit > 0) begin
      while (tr.size() > limit) void'(tr.pop_back());
      if (kill) tr.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
      else tr.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    end
    foreach (tr[k]) exp_q.push_back(tr[k]);
  endtask

  task automatic do_poke();
    melodySelect = 4'($urandom);
    start = (exp_q.size() > 0) && exp_q[0].busy &&
            ($urandom_range(0, 3) == 0);
  endtask

  task automatic drain(input bit poke);
    int g = 0;
    while (exp_q.size() > 0 && g < 4000) begin
      if (poke) do_poke();
      @(posedge clk); #1;
      g++;
    end
    start = 1'b0;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout left=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_melody(input int sel, input bit lp,
                            input int limit, input bit poke,
                            input bit kill);
    @(posedge clk); #1;
    melodySelect = 4'(sel);
    loopEn = lp;
    start = 1'b1;
    model_run(sel, lp, limit, kill);
    @(posedge clk); #1;
    start = 1'b0;
    if (limit > 0) begin
      for (int k = 1; k < limit; k++) begin
        if (poke) do_poke();
        @(posedge clk); #1;
      end
      start = 1'b0;
      if (kill) reset = 1'b1;
      else stop = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      stop = 1'b0;
    end
    drain(poke);
    loopEn = 1'b0;
  endtask

  task automatic start_stop_same();
    @(posedge clk); #1;
    melodySelect = 4'd3;
    start = 1'b1;
    stop = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    drain(0);
  endtask

  initial begin
    for (int m = 0; m < 16; m++)
      for (int i = 0; i < 32; i++) begin
        rom_tone[m][i] = 4'h0;
        rom_len[m][i]  = 4'd0;
      end
    // SOS: dots, silence, dashes, silence, dots
    for (int i = 0; i < 11; i++) begin
      rom_tone[0][i] = 4'h2;
      rom_len[0][i]  = (i >= 4 && i <= 6) ? 4'd3 : 4'd1;
    end
    rom_tone[0][3] = 4'hF; rom_len[0][3] = 4'd3;
    rom_tone[0][7] = 4'hF; rom_len[0][7] = 4'd3;
    rom_tone[4][0] = 4'h0; rom_len[4][0] = 4'd2;
    rom_tone[5][0] = 4'h1; rom_len[5][0] = 4'd1;
    for (int i = 0; i < 32; i++) begin
      rom_tone[15][i] = (i % 9 == 8) ? 4'hF : 4'(i % 8);
      rom_len[15][i]  = 4'd1;
    end
    for (int m = 6; m < 15; m++)
      for (int i = 0; i < 32; i++) begin
        rom_tone[m][i] = ($urandom_range(0, 8) == 8) ?
                         4'hF : 4'($urandom_range(0, 7));
        rom_len[m][i]  = ($urandom_range(0, 5) == 0) ?
                         4'd0 : 4'($urandom_range(1, 3));
      end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0, 1, 0));
    drain(0);

    run_melody(4, 0, 0, 0, 0);
    run_melody(0, 0, 0, 1, 0);
    run_melody(0, 0, 4, 0, 0);
    run_melody(5, 1, 30, 1, 0);
    run_melody(15, 0, 0, 1, 0);
    start_stop_same();
    run_melody(4, 0, 10, 0, 1);
    run_melody(4, 0, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      int sel = $urandom_range(6, 14);
      bit lp = ($urandom_range(0, 3) == 0);
      int lim = 0;
      if (lp) lim = $urandom_range(20, 80);
      else if ($urandom_range(0, 2) == 0)
        lim = $urandom_range(1, 40);
      run_melody(sel, lp, lim, 1, 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
